// File: rtl/mul4_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the
// mul4_share_arb block and its multiplier core.
package mul4_arb_pkg;

    localparam int OPW     = 4;
    localparam int PRODW   = 8;
    localparam int MAXN    = 8;
    localparam int IDMAX_W = 3;

    // Response payload; id is sized for the largest legal requester count.
    typedef struct packed {
        logic [PRODW-1:0]   product;
        logic [IDMAX_W-1:0] id;
    } rsp_t;

    // Arbitration result: found is low when no requester is valid.
    typedef struct packed {
        logic               found;
        logic [IDMAX_W-1:0] idx;
    } pick_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

    // Scan from ptr upward, wrapping modulo n, and return the first valid index.
    function automatic pick_t rr_pick(input logic [MAXN-1:0] valid,
                                      input logic [IDMAX_W-1:0] ptr,
                                      input int n);
        pick_t r;
        int    idx;
        r = '0;
        for (int k = 0; k < MAXN; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !r.found && valid[idx]) begin
                r.found = 1'b1;
                r.idx   = IDMAX_W'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul4x4_core.sv
// Purely combinational 4x4 unsigned multiplier with a full 8-bit product.
module mul4x4_core
    import mul4_arb_pkg::*;
(
    input  logic [OPW-1:0]   i_a,
    input  logic [OPW-1:0]   i_b,
    output logic [PRODW-1:0] o_p
);

    assign o_p = PRODW'(i_a) * PRODW'(i_b);

endmodule

// File: rtl/mul4_share_arb.sv
// Round-robin arbiter sharing one 4x4 multiplier among N_REQ requesters.
// Results leave through a single registered response channel tagged with
// the requester index. Defining MUL4_ARB_PIPE_EN inserts a stage register
// between the core and the response register (latency 2 instead of 1).
module mul4_share_arb
    import mul4_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PRODW-1:0]     rsp_product,
    output logic [ID_W-1:0]      rsp_id
);

    logic [IDMAX_W-1:0] r_rr_ptr;
    rsp_state_e         r_state;
    rsp_state_e         w_state_nxt;
    rsp_t               r_rsp;
    rsp_t               w_rsp_load;
    pick_t              w_pick;
    logic               w_can_accept;
    logic               w_xfer;
    logic               w_push;
    logic               w_pop;
    logic [OPW-1:0]     w_a;
    logic [OPW-1:0]     w_b;
    logic [PRODW-1:0]   w_prod;
    logic               w_unused_id;

    assign w_pick = rr_pick(MAXN'(req_valid), r_rr_ptr, N_REQ);
    assign w_pop  = (r_state == FULL) && rsp_ready;
    // Reset gates the grant so nothing is accepted during the reset cycle.
    assign w_xfer = !rst && w_pick.found && w_can_accept;

`ifdef MUL4_ARB_PIPE_EN
    logic r_stg_valid;
    rsp_t r_stg;
    logic w_stg_adv;

    // The stage moves forward whenever the response register can take it.
    assign w_stg_adv    = (r_state == EMPTY) || rsp_ready;
    assign w_can_accept = !r_stg_valid || w_stg_adv;
    assign w_push       = w_stg_adv && r_stg_valid;
    assign w_rsp_load   = r_stg;

    // Intermediate stage between the core and the response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_valid <= 1'b0;
            r_stg       <= '0;
        end else if (w_xfer) begin
            r_stg_valid <= 1'b1;
            r_stg       <= '{product: w_prod, id: w_pick.idx};
        end else if (w_stg_adv) begin
            r_stg_valid <= 1'b0;
        end
    end
`else
    assign w_can_accept = (r_state == EMPTY) || rsp_ready;
    assign w_push       = w_xfer;
    assign w_rsp_load   = '{product: w_prod, id: w_pick.idx};
`endif

    // Route the granted requester's operands into the shared core.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick.idx == IDMAX_W'(i)) begin
                w_a = req_a[4*i +: 4];
                w_b = req_b[4*i +: 4];
            end
        end
    end

    // One-hot accept for the granted requester only when a result can be taken.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_xfer && (w_pick.idx == IDMAX_W'(i));
        end
    end

    mul4x4_core u_core (
        .i_a (w_a),
        .i_b (w_b),
        .o_p (w_prod)
    );

    // Round-robin pointer moves past the winner on every transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_pick.idx == IDMAX_W'(N_REQ - 1)) ? '0 : w_pick.idx + 1'b1;
        end
    end

    // Response occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Push wins over pop so a simultaneous pop/push keeps the register full.
    always_comb begin
        w_state_nxt = r_state;
        if (w_push) begin
            w_state_nxt = FULL;
        end else if (w_pop) begin
            w_state_nxt = EMPTY;
        end
    end

    // Response payload; holds whenever nothing new is pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp <= '0;
        end else if (w_push) begin
            r_rsp <= w_rsp_load;
        end
    end

    assign rsp_valid   = (r_state == FULL);
    assign rsp_product = r_rsp.product;
    assign rsp_id      = r_rsp.id[ID_W-1:0];
    assign w_unused_id = ^r_rsp.id;

endmodule

// File: tb/tb_mul4_share_arb.sv
// Randomized and directed bench for mul4_share_arb against a cycle model
// written from the arbitration and response-register rules.
module tb_mul4_share_arb;

    localparam int N = 4;
`ifdef MUL4_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_product;
    logic [1:0]    rsp_id;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: output slot (s1) and, when piped, intermediate slot (s0).
    int         m_ptr = 0;
    bit         s1v = 0;
    logic [7:0] s1p = '0;
    int         s1id = 0;
    bit         s0v = 0;
    logic [7:0] s0p = '0;
    int         s0id = 0;

    mul4_share_arb #(.N_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] prod_of(input logic [15:0] a, input logic [15:0] b, input int i);
        return {4'b0, a[4*i +: 4]} * {4'b0, b[4*i +: 4]};
    endfunction

    function automatic int m_pick();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit m_can();
`ifdef MUL4_ARB_PIPE_EN
        return !s0v || !s1v || rsp_ready;
`else
        return !s1v || rsp_ready;
`endif
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = m_pick();
        if (!rst && g >= 0 && m_can()) r[g] = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [15:0] a, input logic [15:0] b,
                         input logic rdy, input logic r);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rdy;
        rst       = r;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        int g;
        bit xfer;
        bit adv;
        logic [7:0] p;
        g    = m_pick();
        xfer = (g >= 0) && m_can() && !rst;
        p    = xfer ? prod_of(req_a, req_b, g) : 8'd0;
        adv  = !s1v || rsp_ready;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; s1v = 0; s1p = '0; s1id = 0; s0v = 0; s0p = '0; s0id = 0;
        end else begin
`ifdef MUL4_ARB_PIPE_EN
            if (adv) begin
                if (s0v) begin s1p = s0p; s1id = s0id; end
                s1v = s0v;
            end
            if (xfer) begin s0v = 1; s0p = p; s0id = g; end
            else if (adv) s0v = 0;
`else
            if (xfer) begin s1v = 1; s1p = p; s1id = g; end
            else if (s1v && rsp_ready && adv) s1v = 0;
`endif
            if (xfer) m_ptr = (g + 1) % N;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive('0, '0, '0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        drive(4'b1111, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        n_vec++;
        if (req_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        tick();
        tick();
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_product !== 8'd0 || rsp_id !== 2'd0) begin
            n_err++; $display("FAIL reset_outputs: got v=%b p=%0d id=%0d want 0/0/0", rsp_valid, rsp_product, rsp_id);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(4'b0100, 16'h0F00, 16'h0F00, 1'b1, 1'b0);
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        drive(4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        for (int i = 1; i < LAT; i++) tick();
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_product !== 8'd225 || rsp_id !== 2'd2) begin
            n_err++; $display("FAIL single_rsp: got v=%b p=%0d id=%0d want 1/225/2", rsp_valid, rsp_product, rsp_id);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [15:0] a;
        logic [15:0] b;
        int k;
        a = 16'($urandom);
        b = 16'($urandom);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(4'b1111, a, b, 1'b1, 1'b0);
            n_vec++;
            if (req_ready !== 4'(1 << (i % N))) begin
                n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, 4'(1 << (i % N)));
            end
            n_vec++;
            if (rsp_valid !== (i >= LAT)) begin
                n_err++; $display("FAIL rr_valid[%0d]: got %b want %b", i, rsp_valid, (i >= LAT));
            end
            if (i >= LAT) begin
                k = (i - LAT) % N;
                n_vec++;
                if (rsp_id !== 2'(k) || rsp_product !== prod_of(a, b, k)) begin
                    n_err++; $display("FAIL rr_rsp[%0d]: got id=%0d p=%0d want id=%0d p=%0d", i, rsp_id, rsp_product, k, prod_of(a, b, k));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom);
        b = 16'($urandom);
        do_reset();
        for (int i = 0; i < LAT + 5; i++) begin
            drive(4'b1111, a, b, 1'b0, 1'b0);
            if (i >= LAT) begin
                n_vec++;
                if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== prod_of(a, b, 0)) begin
                    n_err++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d p=%0d want 0000/1/0/%0d", i, req_ready, rsp_valid, rsp_id, rsp_product, prod_of(a, b, 0));
                end
            end
            tick();
        end
        drive(4'b1111, a, b, 1'b1, 1'b0);
        n_vec++;
        if (req_ready !== 4'(1 << LAT)) begin
            n_err++; $display("FAIL bp_release_ready: got %b want %b", req_ready, 4'(1 << LAT));
        end
        tick();
        drive(4'b0000, a, b, 1'b0, 1'b0);
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_product !== prod_of(a, b, 1)) begin
            n_err++; $display("FAIL bp_no_bubble: got v=%b id=%0d p=%0d want 1/1/%0d", rsp_valid, rsp_id, rsp_product, prod_of(a, b, 1));
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0111, 16'h1234, 16'h5678, 1'b1, 1'b0);
            tick();
        end
        drive(4'b1010, 16'h1234, 16'h5678, 1'b1, 1'b0);
        n_vec++;
        if (req_ready !== 4'b1000) begin
            n_err++; $display("FAIL wrap_first: got %b want 1000", req_ready);
        end
        tick();
        drive(4'b1010, 16'h1234, 16'h5678, 1'b1, 1'b0);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++; $display("FAIL wrap_second: got %b want 0010", req_ready);
        end
        tick();
        drive(4'b1111, 16'h1234, 16'h5678, 1'b1, 1'b0);
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL wrap_ptr: got %b want 0100", req_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom) | 16'h1111;
        b = 16'($urandom) | 16'h1111;
        do_reset();
        for (int i = 0; i <= LAT; i++) begin
            drive(4'b1111, a, b, 1'b0, 1'b0);
            tick();
        end
        drive(4'b1111, a, b, 1'b0, 1'b1);
        n_vec++;
        if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
            n_err++; $display("FAIL midrst_pre: got v=%b rdy=%b want 1/0000", rsp_valid, req_ready);
        end
        tick();
        drive(4'b1010, a, b, 1'b0, 1'b0);
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_product !== 8'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0010) begin
            n_err++; $display("FAIL midrst_post: got v=%b p=%0d id=%0d rdy=%b want 0/0/0/0010", rsp_valid, rsp_product, rsp_id, req_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [15:0]  ha;
        logic [15:0]  hb;
        logic [N-1:0] taken;
        logic         rdy;
        logic         r;
        v = '0; ha = '0; hb = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    v[i] = 1'b1;
                    ha[4*i +: 4] = 4'($urandom);
                    hb[4*i +: 4] = 4'($urandom);
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 49) == 0);
            drive(v, ha, hb, rdy, r);
            n_vec++;
            if (req_ready !== m_ready()) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, m_ready());
            end
            n_vec++;
            if (rsp_valid !== s1v || rsp_product !== s1p || rsp_id !== 2'(s1id)) begin
                n_err++; $display("FAIL rand_rsp[%0d]: got v=%b p=%0d id=%0d want %b/%0d/%0d", c, rsp_valid, rsp_product, rsp_id, s1v, s1p, s1id);
            end
            taken = req_ready & v;
            tick();
            v = v & ~taken;
        end
    endtask

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul4_share_arb.md
# mul4_share_arb

Round-robin arbiter that time-shares one 4x4 unsigned multiplier core among `N_REQ` requesters. Each requester presents operands over a valid/ready channel. The block grants one requester per cycle, multiplies, and returns the 8-bit product on a single registered response channel tagged with the requester index. It sits between the operand producers and the shared multiplier datapath, and is the only path into that core.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  `N_REQ`: per-requester operand valid.
- `req_ready`  out  `N_REQ`: per-requester accept; at most one bit high per cycle.
- `req_a`  in  `4*N_REQ`: operand A; requester i uses bits [4i+3:4i].
- `req_b`  in  `4*N_REQ`: operand B, packed the same way.
- `rsp_valid`  out  1: response register holds a result.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_product`  out  8: unsigned product A*B, full range 0..225.
- `rsp_id`  out  `ID_W`: index of the requester that produced this product.

## Operation
- Output register state: EMPTY (`rsp_valid`=0) or FULL (`rsp_valid`=1).
- `can_accept` = last stage empty OR (`rsp_valid` & `rsp_ready`).
- Arbitration: round-robin pointer `rr_ptr`. Search starts at `rr_ptr` and wraps modulo `N_REQ`; the first requester with `req_valid`=1 is granted.
- `req_ready[g]` = 1 only for the granted requester `g`, and only when `can_accept`=1. It is combinational from `req_valid`, `rr_ptr` and `can_accept`.
- A transfer occurs on `req_valid[g]` & `req_ready[g]`. On a transfer:
  - the operands pass through the core into the next stage;
  - the result is tagged with `g`;
  - `rr_ptr` ← (g+1) mod `N_REQ`.
- With no transfer, `rr_ptr` holds. Non-granted requesters see `req_ready`=0 and must hold their operands stable.
- Push and pop in the same cycle while FULL: the register reloads with the new result and `rsp_valid` stays 1. There is no bubble.
- Pop with no push: the state goes to EMPTY.
- Response stability: while `rsp_valid`=1 & `rsp_ready`=0, `rsp_product` and `rsp_id` hold.
- Arithmetic: 4b×4b unsigned with an 8-bit result; there is no truncation, so bit 7 is live (e.g. 15*15=225=8'hE1).
- Reset, including mid-operation:
  - `rsp_valid`=0, `rsp_product`=0, `rsp_id`=0, `rr_ptr`=0;
  - any pipe stage is cleared;
  - in-flight results are discarded;
  - `req_ready`=0 during the reset cycle.

## Timing
- Request-to-response latency is 1 cycle: a transfer at edge n gives `rsp_valid`=1 after edge n.
- Throughput is 1 result per cycle while `rsp_ready`=1.
- Fairness: a continuously valid requester is granted within `N_REQ` transfers.
- Backpressure: with `rsp_ready`=0 and FULL, all `req_ready`=0 until a pop.

## Configuration
- `MUL4_ARB_PIPE_EN` defined: adds a stage register (valid, product, id) between the core and the response register.
  - Latency becomes 2 cycles.
  - The stage advances when the response register is empty or popping.
  - `can_accept` = stage empty OR stage advancing.
  - Throughput stays at 1 per cycle.
  - The stage resets to empty.
- Undefined: no stage; behaviour is exactly as above.

## Structure
- Shared package `mul4_arb_pkg` holds:
  - `OPW`=4 and `PRODW`=8;
  - a `rsp_t` struct {product, id};
  - function `rr_pick(valid, ptr)`, which returns the grant index and a found flag.
- Sub-module `mul4x4_core`: purely combinational 4x4 → 8 unsigned multiplier. It is instantiated once; all arbitration and registers stay in the top.

## Test plan
- Single request: after reset, requester 2 presents A=15, B=15 with `rsp_ready`=1 → `req_ready[2]`=1 on that cycle; next cycle `rsp_valid`=1, `rsp_product`=225, `rsp_id`=2.
- Round-robin: all 4 requesters valid continuously, `rsp_ready`=1 → grants 0,1,2,3,0,…; `rsp_id` follows, with one result every cycle.
- Backpressure: `rsp_ready`=0 for 5 cycles while FULL → all `req_ready`=0, outputs hold; on the release cycle a pop and a push happen together, with no bubble.
- Wrap and skip: `rr_ptr`=3, only requesters 1 and 3 valid → 3 granted, then 1; `rr_ptr` ends at 2.
- Reset mid-stream: assert `rst` while FULL with pending requests → next cycle `rsp_valid`=0, outputs 0; after release the first grant goes to the lowest valid index.
- `MUL4_ARB_PIPE_EN`: repeat the round-robin test → first `rsp_valid` arrives 2 cycles after the first transfer, then 1 result per cycle, with the same products and ids in order.
